// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sizing helpers for the data-memory arbiter.
// Imported by the interface, the saturating counter and the top.
package dmem_arb_pkg;

   typedef enum logic {
      ARB_CPU = 1'b0,
      ARB_IO  = 1'b1
   } arb_state_e;

   localparam int DEF_AW         = 32;
   localparam int DEF_DW         = 32;
   localparam int DEF_STARVE_MAX = 8;
   localparam int DEF_IO_BURST   = 4;

   // Bits needed to hold the values 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the shared data-memory port: CPU side, I/O master side and RAM side.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface dmem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);

   logic          cpu_active;
   logic [AW-1:0] cpu_address;
   logic [DW-1:0] cpu_data;
   logic          cpu_wren;
   logic [DW-1:0] cpu_q;
   logic          cpu_stall;

   logic          io_req;
   logic [AW-1:0] io_address;
   logic [DW-1:0] io_data;
   logic          io_wren;
   logic          io_gnt;
   logic [DW-1:0] io_rdata;
   logic          io_rvalid;

   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data;
   logic          mem_wren;
   logic [DW-1:0] mem_q;

   modport slave (
      input  cpu_active, cpu_address, cpu_data, cpu_wren,
      input  io_req, io_address, io_data, io_wren,
      input  mem_q,
      output cpu_q, cpu_stall,
      output io_gnt, io_rdata, io_rvalid,
      output mem_address, mem_data, mem_wren
   );

   modport master (
      output cpu_active, cpu_address, cpu_data, cpu_wren,
      output io_req, io_address, io_data, io_wren,
      output mem_q,
      input  cpu_q, cpu_stall,
      input  io_gnt, io_rdata, io_rvalid,
      input  mem_address, mem_data, mem_wren
   );

endinterface

// File: rtl/dmem_arbiter_arb_sat_counter.sv
// Saturating up-counter with clear, load-1 and increment controls (priority in that order).
// Used for the arbiter's starvation and burst counters.
module arb_sat_counter
   import dmem_arb_pkg::*;
#(
   parameter int MAX = 1,
   parameter int W   = cnt_width(MAX)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         load1,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load1) begin
         cnt <= W'(1);
      end else if (inc && (cnt != MAX_V)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU memory stage and one I/O master.
// Optional macro DMEM_ARB_STATS_EN adds free-running grant/stall counters (tied to 0 otherwise).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW         = DEF_AW,
   parameter int DW         = DEF_DW,
   parameter int STARVE_MAX = DEF_STARVE_MAX,
   parameter int IO_BURST   = DEF_IO_BURST
) (
   input  logic                clock,
   input  logic                reset,
   dmem_arbiter_if.slave       bus,
   output logic [31:0]         stat_io_grants,
   output logic [31:0]         stat_cpu_stalls
);

   localparam int SW = cnt_width(STARVE_MAX);
   localparam int BW = cnt_width(IO_BURST);
   localparam logic [SW-1:0] STARVE_V = SW'(STARVE_MAX);
   localparam logic [BW-1:0] BURST_V  = BW'(IO_BURST);

   arb_state_e    state_q, state_d;
   logic [SW-1:0] starve_cnt;
   logic [BW-1:0] burst_cnt;
   logic          s_clr, s_load1, s_inc;
   logic          b_clr, b_load1, b_inc;
   logic          gnt_raw, gnt, stall;
   logic          rvalid_q;

   arb_sat_counter #(.MAX(STARVE_MAX), .W(SW)) u_starve (
      .clock (clock),
      .reset (reset),
      .clr   (s_clr),
      .load1 (s_load1),
      .inc   (s_inc),
      .cnt   (starve_cnt)
   );

   arb_sat_counter #(.MAX(IO_BURST), .W(BW)) u_burst (
      .clock (clock),
      .reset (reset),
      .clr   (b_clr),
      .load1 (b_load1),
      .inc   (b_inc),
      .cnt   (burst_cnt)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ARB_CPU;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= gnt & ~bus.io_wren;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_raw = 1'b0;
      s_clr   = 1'b0;
      s_load1 = 1'b0;
      s_inc   = 1'b0;
      b_clr   = 1'b0;
      b_load1 = 1'b0;
      b_inc   = 1'b0;
      case (state_q)
         ARB_CPU: begin
            gnt_raw = bus.io_req & (~bus.cpu_active | (starve_cnt == STARVE_V));
            if (gnt_raw) begin
               state_d = ARB_IO;
               b_load1 = 1'b1;
               s_clr   = 1'b1;
            end else if (bus.io_req) begin
               s_inc = 1'b1;
            end else begin
               s_clr = 1'b1;
            end
         end
         ARB_IO: begin
            gnt_raw = bus.io_req & (~bus.cpu_active | (burst_cnt < BURST_V));
            if (gnt_raw) begin
               b_inc = 1'b1;
            end else begin
               // A denial that ends a burst already counts toward the next forced slot.
               state_d = ARB_CPU;
               b_clr   = 1'b1;
               s_load1 = bus.io_req;
            end
         end
         default: state_d = ARB_CPU;
      endcase
   end

   // Reset is folded in so nothing is granted or written while reset is held.
   assign gnt   = reset & gnt_raw;
   assign stall = bus.cpu_active & gnt;

   assign bus.io_gnt      = gnt;
   assign bus.cpu_stall   = stall;
   assign bus.mem_address = gnt ? bus.io_address : bus.cpu_address;
   assign bus.mem_data    = gnt ? bus.io_data    : bus.cpu_data;
   assign bus.mem_wren    = reset & (gnt ? bus.io_wren : (bus.cpu_wren & bus.cpu_active));
   assign bus.io_rvalid   = rvalid_q;
   assign bus.io_rdata    = rvalid_q ? bus.mem_q : '0;
   assign bus.cpu_q       = bus.mem_q;

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_io_grants  <= '0;
         stat_cpu_stalls <= '0;
      end else begin
         if (gnt)   stat_io_grants  <= stat_io_grants + 32'd1;
         if (stall) stat_cpu_stalls <= stat_cpu_stalls + 32'd1;
      end
   end
`else
   assign stat_io_grants  = '0;
   assign stat_cpu_stalls = '0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipelined CPU's memory stage and one external I/O master, such as the board-scan/LED engine.
- Sits between the processor's address_dmem/data/wren/q_dmem nets and the RAM.
- The CPU has default priority. The I/O master gets free cycles, and a guaranteed slot once it has waited STARVE_MAX cycles.
- cpu_stall is fed into the processor's stall term (OR'd with its multdiv/hazard stall) so a stolen cycle freezes the pipeline.

Parameters:
- AW, 32, address width of all address ports.
- DW, 32, data width.
- STARVE_MAX, 8, number of ungranted io_req cycles before the I/O master is forced in; legal range ≥ 1.
- IO_BURST, 4, maximum consecutive I/O grants while the CPU is requesting; legal range ≥ 1.

Ports:
- clock, in, 1: master clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset (reset == 0 resets).
- cpu_active, in, 1: the memory-stage instruction is lw or sw.
- cpu_address, in, AW: CPU address.
- cpu_data, in, DW: CPU store data.
- cpu_wren, in, 1: CPU store.
- cpu_q, out, DW: read data to the CPU; equals mem_q.
- cpu_stall, out, 1: the CPU access is denied this cycle.
- io_req, in, 1: I/O master requests the port.
- io_address, in, AW: I/O address.
- io_data, in, DW: I/O write data.
- io_wren, in, 1: I/O write.
- io_gnt, out, 1: I/O access is performed this cycle.
- io_rdata, out, DW: I/O read data.
- io_rvalid, out, 1: io_rdata valid, one cycle after a read grant.
- mem_address, out, AW: RAM address.
- mem_data, out, DW: RAM write data.
- mem_wren, out, 1: RAM write enable.
- mem_q, in, DW: RAM read data; one-cycle read latency.

Behaviour:
- Reset (reset low, asynchronous):
  - state=ARB_CPU; starve_cnt=0, burst_cnt=0, io_rvalid=0.
  - Outputs during reset: io_gnt=0, cpu_stall=0, mem_wren=0.
- States: ARB_CPU, ARB_IO (registered). io_gnt and cpu_stall are combinational from state, counters, io_req and cpu_active.
- ARB_CPU:
  - io_gnt = io_req & (~cpu_active | starve_cnt==STARVE_MAX).
  - If io_gnt: next=ARB_IO, burst_cnt←1, starve_cnt←0.
  - Else if io_req: starve_cnt increments, saturating at STARVE_MAX.
  - Else: starve_cnt←0.
- ARB_IO:
  - io_gnt = io_req & (~cpu_active | burst_cnt<IO_BURST).
  - If io_gnt: stay in ARB_IO; burst_cnt increments, saturating at IO_BURST.
  - Else: next=ARB_CPU, burst_cnt←0. If io_req is still high, starve_cnt←1 (the denial cycle counts).
- cpu_stall = cpu_active & io_gnt.
- Memory mux:
  - io_gnt=1: mem_address/mem_data/mem_wren come from the io_* inputs.
  - Otherwise: they come from cpu_*, with mem_wren = cpu_wren & cpu_active.
- Read return:
  - io_rvalid ← io_gnt & ~io_wren.
  - io_rdata = io_rvalid ? mem_q : 0.
  - cpu_q = mem_q always; the CPU discards it while stalled.
- Simultaneous events:
  - cpu_active and io_req in the same cycle in ARB_CPU, with starve_cnt<STARVE_MAX: CPU wins; starve_cnt increments.
  - Forced slot: exactly one stolen cycle, unless the I/O master stays in ARB_IO (bounded by IO_BURST).
- Worst-case CPU stall per I/O episode is IO_BURST cycles.
- io_req dropped mid-burst: the arbiter returns to ARB_CPU the next cycle; no grant while io_req=0.
- Reset asserted mid-read: the pending io_rvalid is cleared and never emitted.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_io_grants[31:0] and stat_cpu_stalls[31:0].
  - Free-running counters of io_gnt cycles and cpu_stall cycles.
  - Wrap at 2^32; cleared by reset.
- Undefined: the ports exist and are tied to 0; no counter flops are synthesized.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding (ARB_CPU=1'b0, ARB_IO=1'b1);
  - default widths;
  - the counter width function clog2(max+1) used for starve_cnt and burst_cnt.
- One sub-module, arb_sat_counter: saturating up-counter with clear/load-1/increment inputs.
  - Instantiated twice, for starve_cnt and burst_cnt.

Test Plan:
1. Reset low mid-burst, with io_req=1 and io_wren=0, granted the previous cycle → io_gnt=0, io_rvalid=0, mem_wren=0 immediately; after release, state ARB_CPU.
2. cpu_active=0, io_req=1, io_address=0x40, io_wren=1, io_data=0xDEAD → io_gnt=1 the same cycle, mem_address=0x40, mem_wren=1, cpu_stall=0.
3. cpu_active=1 constantly, io_req=1 from cycle 0, STARVE_MAX=8 → io_gnt low for cycles 0–7, high at cycle 8 with cpu_stall=1, then held in ARB_IO up to IO_BURST=4 total grant cycles.
4. I/O read at 0x10, with RAM[0x10]=0x1234 → io_gnt at cycle N; io_rvalid=1 and io_rdata=0x1234 at cycle N+1; io_rvalid=0 at N+2.
5. IO_BURST=4, cpu_active=1, io_req held after a forced grant → exactly 4 consecutive io_gnt cycles, then the CPU gets cycle 5, starve_cnt restarts at 1.
6. Build with DMEM_ARB_STATS_EN, run scenario 3 → stat_io_grants=4, stat_cpu_stalls=4. Without the macro → both read 0.
